// File: rtl/regfile_dump_if.sv
// Beat stream from the register-file dumper to the debug/trace path.
// Each beat carries one (index, word) pair and a last-beat marker.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output index, output data, output last, input ready);
  modport slave  (input valid, input index, input data, input last, output ready);
endinterface

// File: rtl/regfile_dump.sv
// Sequential debug reader: walks register-file port A1/RD1 over an inclusive
// index range, streams (index, word) beats and keeps an XOR checksum of them.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  regfile_dump_if.master    o_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_range_err,
  output logic [DATA_W-1:0] o_checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [ADDR_W-1:0] r_last_idx;
  logic [ADDR_W-1:0] r_out_index;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_checksum;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_err;
  logic              r_done;
  logic              r_range_err;

  logic w_fire;
  logic w_range_ok;

  assign w_fire     = r_out_valid && o_out.ready;
  assign w_range_ok = (i_first <= i_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rf_addr   <= '0;
      r_last_idx  <= '0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_checksum  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_checksum <= '0;
            if (w_range_ok) begin
              r_last_idx <= i_last;
              r_rf_addr  <= i_first;
              r_err      <= 1'b0;
              r_state    <= S_READ;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          // RD1 is sampled here, so a write landing on this same edge is not seen.
          r_out_data  <= i_rf_data;
          r_out_index <= r_rf_addr;
          r_out_last  <= (r_rf_addr == r_last_idx);
          r_out_valid <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (w_fire) begin
            r_checksum  <= r_checksum ^ r_out_data;
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_state <= S_DONE;
            end else begin
              // Never increments past the latched last index, so no wrap.
              r_rf_addr <= r_rf_addr + 1'b1;
              r_state   <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_range_err <= r_err;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rf_addr   = r_rf_addr;
  assign o_out.valid = r_out_valid;
  assign o_out.index = r_out_index;
  assign o_out.data  = r_out_data;
  assign o_out.last  = r_out_last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_range_err = r_range_err;
  assign o_checksum  = r_checksum;

endmodule
